// File: rtl/decode_alu_stage.sv
// decode_alu_stage
//   Registered ALU decode stage between fetch and execute. Each {instr, pc}
//   accepted on the input handshake is decoded into one ALU control bundle
//   and presented one cycle later on the output handshake, strictly in order.
//   Instructions that cannot be decoded still flow, with illegal=1.
//
//   Encodings
//     alu_mode : 0 ADD, 1 SUB, 2 SLL, 3 XOR, 4 SRL, 5 SRA, 6 OR, 7 AND
//     eval_mode: 0 EQ, 1 NE, 2 LT, 3 GE
//     in1_sel  : 0 RS1, 1 PC, 2 ZERO
//     in2_sel  : 0 RS2, 1 IMM, 2 FOUR
//     out_sel  : 0 ALU, 1 EVAL
//
//   Ports
//     clk, rst (sync, active high), flush (sync discard of held entries)
//     in_valid/in_ready/instr_in/pc_in         : fetch side handshake
//     out_valid/out_ready/instr_out/pc_out     : execute side handshake
//     alu_mode, eval_mode, sign_ext, in1_sel, in2_sel, out_sel,
//     md_en, md_op, illegal                    : decoded control bundle
//
//   state    | meaning
//   ST_EMPTY | nothing held, out_valid=0
//   ST_ONE   | output register holds a bundle
//   ST_TWO   | output register and skid register both hold bundles (SKID=1 only)
module decode_alu_stage #(
    parameter int XLEN      = 32,
    parameter bit SUPPORT_M = 1'b1,
    parameter bit SKID      = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr_in,
    input  logic [XLEN-1:0] pc_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     instr_out,
    output logic [XLEN-1:0] pc_out,
    output logic [2:0]      alu_mode,
    output logic [1:0]      eval_mode,
    output logic            sign_ext,
    output logic [1:0]      in1_sel,
    output logic [1:0]      in2_sel,
    output logic            out_sel,
    output logic            md_en,
    output logic [2:0]      md_op,
    output logic            illegal
);

    localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_SLL = 3'd2, ALU_XOR = 3'd3;
    localparam logic [2:0] ALU_SRL = 3'd4, ALU_SRA = 3'd5, ALU_OR  = 3'd6, ALU_AND = 3'd7;
    localparam logic [1:0] EVAL_EQ = 2'd0, EVAL_NE = 2'd1, EVAL_LT = 2'd2, EVAL_GE = 2'd3;
    localparam logic [1:0] IN1_RS1 = 2'd0, IN1_PC  = 2'd1, IN1_ZERO = 2'd2;
    localparam logic [1:0] IN2_RS2 = 2'd0, IN2_IMM = 2'd1, IN2_FOUR = 2'd2;
    localparam logic       OUT_ALU = 1'b0, OUT_EVAL = 1'b1;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [2:0]      alu_mode;
        logic [1:0]      eval_mode;
        logic            sign_ext;
        logic [1:0]      in1_sel;
        logic [1:0]      in2_sel;
        logic            out_sel;
        logic            md_en;
        logic [2:0]      md_op;
        logic            illegal;
    } bundle_t;

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

    state_t  state_q, state_d;
    bundle_t out_q, out_d;
    bundle_t skid_q, skid_d;
    bundle_t dec;
    logic    in_ready_q;
    logic    accept, drain;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       alt, ill;

    assign opcode = instr_in[6:0];
    assign f3     = instr_in[14:12];
    assign f7     = instr_in[31:25];

    // ---------------- decode ----------------
    always_comb begin
        dec          = '0;
        dec.instr    = instr_in;
        dec.pc       = pc_in;
        dec.sign_ext = 1'b1;
        ill          = 1'b0;
        alt          = 1'b0;
        case (opcode)
            7'd3: begin
                dec.in2_sel = IN2_IMM;
                ill = (f3 == 3'b011) || (f3[2:1] == 2'b11);
            end
            7'd35: begin
                dec.in2_sel = IN2_IMM;
                ill = (f3 >= 3'd3);
            end
            7'd23: begin
                dec.in1_sel = IN1_PC;
                dec.in2_sel = IN2_IMM;
            end
            7'd55: begin
                dec.in1_sel = IN1_ZERO;
                dec.in2_sel = IN2_IMM;
            end
            7'd111: begin
                dec.in1_sel = IN1_PC;
                dec.in2_sel = IN2_FOUR;
            end
            7'd103: begin
                dec.in1_sel = IN1_PC;
                dec.in2_sel = IN2_FOUR;
                ill = (f3 != 3'd0);
            end
            7'd99: begin
                dec.alu_mode = ALU_SUB;
                case (f3)
                    3'b000:  dec.eval_mode = EVAL_EQ;
                    3'b001:  dec.eval_mode = EVAL_NE;
                    3'b100:  dec.eval_mode = EVAL_LT;
                    3'b101:  dec.eval_mode = EVAL_GE;
                    3'b110:  begin dec.eval_mode = EVAL_LT; dec.sign_ext = 1'b0; end
                    3'b111:  begin dec.eval_mode = EVAL_GE; dec.sign_ext = 1'b0; end
                    default: ill = 1'b1;
                endcase
            end
            7'd19, 7'd51: begin
                if (opcode == 7'd19) begin
                    dec.in2_sel = IN2_IMM;
                    // For immediates only the shift-right form carries an opcode bit in func7.
                    alt = (f3 == 3'b101) && (f7 == 7'h20);
                    ill = ((f3 == 3'b001) && (f7 != 7'h00)) ||
                          ((f3 == 3'b101) && (f7 != 7'h00) && (f7 != 7'h20));
                end else begin
                    alt = (f7 == 7'h20);
                    ill = !((f7 == 7'h00) ||
                            (alt && ((f3 == 3'b000) || (f3 == 3'b101))) ||
                            ((f7 == 7'h01) && SUPPORT_M));
                end
                if (opcode == 7'd51 && f7 == 7'h01) begin
                    dec.md_en = 1'b1;
                    dec.md_op = f3;
                end else begin
                    case (f3)
                        3'b000:  dec.alu_mode = alt ? ALU_SUB : ALU_ADD;
                        3'b001:  dec.alu_mode = ALU_SLL;
                        3'b010:  begin dec.alu_mode = ALU_SUB; dec.eval_mode = EVAL_LT;
                                       dec.out_sel = OUT_EVAL; end
                        3'b011:  begin dec.alu_mode = ALU_SUB; dec.eval_mode = EVAL_LT;
                                       dec.out_sel = OUT_EVAL; dec.sign_ext = 1'b0; end
                        3'b100:  dec.alu_mode = ALU_XOR;
                        3'b101:  dec.alu_mode = alt ? ALU_SRA : ALU_SRL;
                        3'b110:  dec.alu_mode = ALU_OR;
                        default: dec.alu_mode = ALU_AND;
                    endcase
                end
            end
            default: ill = 1'b1;
        endcase
        // Illegal instructions carry a fixed, harmless control bundle.
        if (ill) begin
            dec.alu_mode  = ALU_ADD;
            dec.eval_mode = EVAL_EQ;
            dec.sign_ext  = 1'b1;
            dec.in1_sel   = IN1_RS1;
            dec.in2_sel   = IN2_RS2;
            dec.out_sel   = OUT_ALU;
            dec.md_en     = 1'b0;
            dec.md_op     = 3'd0;
            dec.illegal   = 1'b1;
        end
    end

    // ---------------- buffering FSM ----------------
    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = SKID ? in_ready_q : (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        out_d   = dec;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        out_d = dec;
                    end else if (accept && SKID) begin
                        skid_d  = dec;
                        state_d = ST_TWO;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (drain) begin
                        out_d   = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            out_q      <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != ST_TWO);
        end
    end

    assign instr_out = out_q.instr;
    assign pc_out    = out_q.pc;
    assign alu_mode  = out_q.alu_mode;
    assign eval_mode = out_q.eval_mode;
    assign sign_ext  = out_q.sign_ext;
    assign in1_sel   = out_q.in1_sel;
    assign in2_sel   = out_q.in2_sel;
    assign out_sel   = out_q.out_sel;
    assign md_en     = out_q.md_en;
    assign md_op     = out_q.md_op;
    assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_decode_alu_stage.sv
module tb_decode_alu_stage;

    localparam logic [2:0] A_ADD = 0, A_SUB = 1, A_SLL = 2, A_XOR = 3, A_SRL = 4, A_SRA = 5, A_OR = 6, A_AND = 7;
    localparam logic [1:0] E_EQ = 0, E_NE = 1, E_LT = 2, E_GE = 3;
    localparam logic [1:0] I1_RS1 = 0, I1_PC = 1, I1_ZERO = 2;
    localparam logic [1:0] I2_RS2 = 0, I2_IMM = 1, I2_FOUR = 2;
    localparam logic [2:0] BASE_ALU [8] = '{A_ADD, A_SLL, A_SUB, A_SUB, A_XOR, A_SRL, A_OR, A_AND};

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [2:0]  alu;
        logic [1:0]  ev;
        logic        se;
        logic [1:0]  i1;
        logic [1:0]  i2;
        logic        os;
        logic        md;
        logic [2:0]  mop;
        logic        ill;
    } bundle_t;

    logic clk = 0;
    always #5 clk = ~clk;

    logic rst = 1, flush = 0;
    // main DUT: SUPPORT_M=1, SKID=1
    logic in_valid = 0, out_ready = 0, in_ready, out_valid;
    logic [31:0] instr_in = 0, pc_in = 0, instr_out, pc_out;
    logic [2:0] alu_mode, md_op;
    logic [1:0] eval_mode, in1_sel, in2_sel;
    logic sign_ext, out_sel, md_en, illegal;
    // second DUT: SUPPORT_M=0, SKID=0
    logic flush0 = 0, in_valid0 = 0, out_ready0 = 0, in_ready0, out_valid0;
    logic [31:0] instr_in0 = 0, pc_in0 = 0, instr_out0, pc_out0;
    logic [2:0] alu_mode0, md_op0;
    logic [1:0] eval_mode0, in1_sel0, in2_sel0;
    logic sign_ext0, out_sel0, md_en0, illegal0;

    decode_alu_stage #(.XLEN(32), .SUPPORT_M(1'b1), .SKID(1'b1)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instr_in(instr_in), .pc_in(pc_in),
        .out_valid(out_valid), .out_ready(out_ready), .instr_out(instr_out), .pc_out(pc_out),
        .alu_mode(alu_mode), .eval_mode(eval_mode), .sign_ext(sign_ext),
        .in1_sel(in1_sel), .in2_sel(in2_sel), .out_sel(out_sel),
        .md_en(md_en), .md_op(md_op), .illegal(illegal));

    decode_alu_stage #(.XLEN(32), .SUPPORT_M(1'b0), .SKID(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .flush(flush0),
        .in_valid(in_valid0), .in_ready(in_ready0), .instr_in(instr_in0), .pc_in(pc_in0),
        .out_valid(out_valid0), .out_ready(out_ready0), .instr_out(instr_out0), .pc_out(pc_out0),
        .alu_mode(alu_mode0), .eval_mode(eval_mode0), .sign_ext(sign_ext0),
        .in1_sel(in1_sel0), .in2_sel(in2_sel0), .out_sel(out_sel0),
        .md_en(md_en0), .md_op(md_op0), .illegal(illegal0));

    int n_total = 0, n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
        return {f7, 5'd3, 5'd2, f3, 5'd1, op};
    endfunction

    // Reference decoder: rules stated per instruction class.
    function automatic bundle_t model(input logic [31:0] ins, input logic [31:0] pc, input bit sup_m);
        bundle_t b;
        logic [6:0] op, f7;
        logic [2:0] f3;
        bit legal, rt, alt;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        b = '0; b.instr = ins; b.pc = pc; b.se = 1'b1;
        legal = 1;
        if (op == 3) begin
            legal = !(f3 inside {3'd3, 3'd6, 3'd7}); b.i2 = I2_IMM;
        end else if (op == 35) begin
            legal = (f3 < 3); b.i2 = I2_IMM;
        end else if (op == 23) begin
            b.i1 = I1_PC; b.i2 = I2_IMM;
        end else if (op == 55) begin
            b.i1 = I1_ZERO; b.i2 = I2_IMM;
        end else if (op == 111 || op == 103) begin
            b.i1 = I1_PC; b.i2 = I2_FOUR;
            if (op == 103) legal = (f3 == 0);
        end else if (op == 99) begin
            legal = !(f3 inside {3'd2, 3'd3});
            b.alu = A_SUB;
            b.ev = f3[2] ? (f3[0] ? E_GE : E_LT) : (f3[0] ? E_NE : E_EQ);
            b.se = !(f3[2] && f3[1]);
        end else if (op == 19 || op == 51) begin
            rt = (op == 51);
            alt = (f7 == 7'h20);
            if (!rt) b.i2 = I2_IMM;
            if (rt && f7 == 7'h01) begin
                legal = sup_m; b.md = 1; b.mop = f3;
            end else begin
                if (rt) legal = (f7 == 0) || (alt && (f3 == 0 || f3 == 5));
                else if (f3 == 1) legal = (f7 == 0);
                else if (f3 == 5) legal = (f7 == 0) || alt;
                b.alu = BASE_ALU[f3];
                if (f3 == 0 && rt && alt) b.alu = A_SUB;
                if (f3 == 5 && alt) b.alu = A_SRA;
                if (f3 == 2 || f3 == 3) begin
                    b.ev = E_LT; b.os = 1; b.se = (f3 == 2);
                end
            end
        end else begin
            legal = 0;
        end
        if (!legal) begin
            b = '0; b.instr = ins; b.pc = pc; b.se = 1; b.ill = 1;
        end
        return b;
    endfunction

    // Scoreboard for the main DUT, checked every cycle on the falling edge.
    bundle_t exp_q[$];
    bit mon_en = 0;
    bundle_t got;
    always @(negedge clk) begin
        if (mon_en) begin
            chk("out_valid_vs_model", out_valid, exp_q.size() != 0);
            chk("in_ready_vs_model", in_ready, exp_q.size() < 2);
            if (out_valid && exp_q.size() != 0) begin
                got = {instr_out, pc_out, alu_mode, eval_mode, sign_ext, in1_sel, in2_sel,
                       out_sel, md_en, md_op, illegal};
                n_total++;
                if (got !== exp_q[0])
                    $display("FAIL bundle: got %h expected %h at %0t", got, exp_q[0], $time);
                else n_pass++;
            end
            if (rst || flush) exp_q.delete();
            else begin
                if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
                if (in_valid && in_ready) exp_q.push_back(model(instr_in, pc_in, 1'b1));
            end
        end
    end

    localparam logic [31:0] I_ADD = 32'h003100B3, I_SUB = 32'h403100B3, I_MUL = 32'h023100B3;
    localparam logic [31:0] I_SLTIU = 32'h00513093, I_BLTU = 32'h0020E063, I_JALR1 = 32'h00009067;

    logic [31:0] vecs[$];

    initial begin
        rst = 1;
        step(); step();
        rst = 0;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_instr_out", instr_out, 0);
        mon_en = 1;

        // 1: ADD then SUB back to back
        out_ready = 1; in_valid = 1; instr_in = I_ADD; pc_in = 32'h100;
        step();
        chk("t1_valid_n1", out_valid, 1);
        chk("t1_alu_add", alu_mode, A_ADD);
        chk("t1_illegal_add", illegal, 0);
        instr_in = I_SUB; pc_in = 32'h104;
        step();
        chk("t1_valid_n2", out_valid, 1);
        chk("t1_alu_sub", alu_mode, A_SUB);
        chk("t1_instr_sub", instr_out, I_SUB);
        // 2: MUL with M support
        instr_in = I_MUL; pc_in = 32'h108;
        step();
        chk("t2_md_en", md_en, 1);
        chk("t2_md_op", md_op, 0);
        chk("t2_illegal", illegal, 0);
        // 3: SLTIU and BLTU
        instr_in = I_SLTIU; pc_in = 32'h10C;
        step();
        chk("t3_sltiu_alu", alu_mode, A_SUB);
        chk("t3_sltiu_eval", eval_mode, E_LT);
        chk("t3_sltiu_sext", sign_ext, 0);
        chk("t3_sltiu_in2", in2_sel, I2_IMM);
        chk("t3_sltiu_out", out_sel, 1);
        instr_in = I_BLTU; pc_in = 32'h110;
        step();
        chk("t3_bltu_alu", alu_mode, A_SUB);
        chk("t3_bltu_eval", eval_mode, E_LT);
        chk("t3_bltu_sext", sign_ext, 0);
        // 4: JALR with func3=1
        instr_in = I_JALR1; pc_in = 32'h1234;
        step();
        chk("t4_illegal", illegal, 1);
        chk("t4_alu", alu_mode, A_ADD);
        chk("t4_in1", in1_sel, I1_RS1);
        chk("t4_in2", in2_sel, I2_RS2);
        chk("t4_sext", sign_ext, 1);
        chk("t4_pc", pc_out, 32'h1234);
        in_valid = 0;
        step();
        chk("t4_drained", out_valid, 0);

        // 5: skid fill with stalled output, then release
        out_ready = 0; in_valid = 1; instr_in = I_ADD; pc_in = 32'h200;
        step();
        instr_in = I_SUB; pc_in = 32'h204;
        step();
        chk("t5_in_ready_full", in_ready, 0);
        instr_in = I_SLTIU; pc_in = 32'h208;
        step();
        chk("t5_in_ready_hold", in_ready, 0);
        chk("t5_stable_instr", instr_out, I_ADD);
        out_ready = 1;
        step();
        chk("t5_second", instr_out, I_SUB);
        chk("t5_ready_again", in_ready, 1);
        step();
        chk("t5_third", instr_out, I_SLTIU);
        in_valid = 0;
        step();
        chk("t5_empty", out_valid, 0);

        // 6: flush from TWO with in_valid asserted
        out_ready = 0; in_valid = 1; instr_in = I_ADD; pc_in = 32'h300;
        step();
        instr_in = I_SUB; pc_in = 32'h304;
        step();
        flush = 1; instr_in = I_MUL; pc_in = 32'h308;
        step();
        flush = 0; in_valid = 0;
        chk("t6_flush_valid", out_valid, 0);
        chk("t6_flush_ready", in_ready, 1);
        out_ready = 1;
        step(); step();
        chk("t6_flush_nothing", out_valid, 0);
        // same via reset
        out_ready = 0; in_valid = 1; instr_in = I_ADD; pc_in = 32'h400;
        step();
        instr_in = I_SUB; pc_in = 32'h404;
        step();
        in_valid = 0; rst = 1;
        step();
        rst = 0;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_ready", in_ready, 1);
        chk("t6_rst_instr", instr_out, 0);
        chk("t6_rst_pc", pc_out, 0);
        out_ready = 1;
        step();
        chk("t6_rst_nothing", out_valid, 0);

        // Decode table sweep, checked by the scoreboard, with intermittent stalls.
        vecs.push_back(mk(7'h12, 3'd5, 7'd55)); vecs.push_back(mk(7'h12, 3'd5, 7'd23));
        vecs.push_back(mk(7'h40, 3'd2, 7'd111)); vecs.push_back(mk(7'h00, 3'd0, 7'd103));
        vecs.push_back(mk(7'h00, 3'd2, 7'd3)); vecs.push_back(mk(7'h00, 3'd3, 7'd3));
        vecs.push_back(mk(7'h00, 3'd4, 7'd3)); vecs.push_back(mk(7'h00, 3'd7, 7'd3));
        vecs.push_back(mk(7'h00, 3'd2, 7'd35)); vecs.push_back(mk(7'h00, 3'd3, 7'd35));
        vecs.push_back(mk(7'h00, 3'd0, 7'd99)); vecs.push_back(mk(7'h00, 3'd1, 7'd99));
        vecs.push_back(mk(7'h00, 3'd5, 7'd99)); vecs.push_back(mk(7'h00, 3'd7, 7'd99));
        vecs.push_back(mk(7'h00, 3'd2, 7'd99)); vecs.push_back(mk(7'h20, 3'd0, 7'd19));
        vecs.push_back(mk(7'h00, 3'd1, 7'd19)); vecs.push_back(mk(7'h20, 3'd1, 7'd19));
        vecs.push_back(mk(7'h20, 3'd5, 7'd19)); vecs.push_back(mk(7'h00, 3'd5, 7'd19));
        vecs.push_back(mk(7'h10, 3'd5, 7'd19)); vecs.push_back(mk(7'h00, 3'd2, 7'd19));
        vecs.push_back(mk(7'h00, 3'd4, 7'd19)); vecs.push_back(mk(7'h00, 3'd6, 7'd19));
        vecs.push_back(mk(7'h00, 3'd7, 7'd19)); vecs.push_back(mk(7'h00, 3'd1, 7'd51));
        vecs.push_back(mk(7'h20, 3'd5, 7'd51)); vecs.push_back(mk(7'h20, 3'd4, 7'd51));
        vecs.push_back(mk(7'h00, 3'd7, 7'd51)); vecs.push_back(mk(7'h00, 3'd3, 7'd51));
        vecs.push_back(mk(7'h01, 3'd5, 7'd51)); vecs.push_back(mk(7'h02, 3'd0, 7'd51));
        vecs.push_back(mk(7'h00, 3'd0, 7'h7F)); vecs.push_back(mk(7'h00, 3'd0, 7'h0F));
        foreach (vecs[i]) begin
            bit acc;
            int guard;
            in_valid = 1; instr_in = vecs[i]; pc_in = 32'h1000 + 4 * i;
            out_ready = (i % 3 != 2);
            guard = 0;
            acc = 0;
            while (!acc && guard < 20) begin
                acc = in_ready;
                step();
                out_ready = 1;
                guard++;
            end
            if (!acc) chk("sweep_accept_timeout", 0, 1);
        end
        in_valid = 0; out_ready = 1;
        step(); step(); step();
        chk("sweep_drained", out_valid, 0);

        // SUPPORT_M=0, SKID=0 instance
        out_ready0 = 0; in_valid0 = 1; instr_in0 = I_MUL; pc_in0 = 32'h500;
        step();
        chk("m0_valid", out_valid0, 1);
        chk("m0_illegal", illegal0, 1);
        chk("m0_md_en", md_en0, 0);
        chk("m0_md_op", md_op0, 0);
        chk("m0_in_ready_stall", in_ready0, 0);
        instr_in0 = I_ADD; pc_in0 = 32'h504;
        out_ready0 = 1;
        #1;
        chk("s0_in_ready_comb", in_ready0, 1);
        step();
        chk("s0_throughput_valid", out_valid0, 1);
        chk("s0_throughput_instr", instr_out0, I_ADD);
        chk("s0_add_legal", illegal0, 0);
        in_valid0 = 0;
        step();
        chk("s0_empty", out_valid0, 0);

        mon_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
